// File: rtl/ingress_filter_pkg.sv
// Shared types and constants for the ingress MAC/checksum filter.
package ingress_filter_pkg;

    // Per-packet filter state: evaluate header, forward packet, or discard packet
    typedef enum logic [1:0] {
        HDR  = 2'd0,
        PASS = 2'd1,
        DROP = 2'd2
    } filter_state_e;

    // Bit positions inside last_drop_reason = {runt, mac, csum}
    localparam int unsigned RSN_CSUM = 0;
    localparam int unsigned RSN_MAC  = 1;
    localparam int unsigned RSN_RUNT = 2;
    localparam int unsigned RSN_W    = 3;

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is presented on dout
// whenever empty is low; a beat written to an empty FIFO appears one cycle later.
module fallthrough_small_fifo #(
    parameter int unsigned WIDTH          = 72,
    parameter int unsigned MAX_DEPTH_BITS = 3
) (
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             nearly_full,
    output logic             empty,
    input  logic             reset,
    input  logic             clk
);

    localparam int unsigned DEPTH = 1 << MAX_DEPTH_BITS;
    localparam logic [MAX_DEPTH_BITS:0] CNT_FULL   = {1'b1, {MAX_DEPTH_BITS{1'b0}}};
    localparam logic [MAX_DEPTH_BITS:0] CNT_NEARLY = CNT_FULL - 1'b1;

    logic [WIDTH-1:0]          mem_q [DEPTH];
    logic [MAX_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [MAX_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [MAX_DEPTH_BITS:0]   count_q, count_d;
    logic                      do_wr, do_rd;

    // Pointer/occupancy update; writes to a full FIFO and reads of an empty one are ignored
    always_comb begin
        do_wr    = wr_en && (count_q != CNT_FULL);
        do_rd    = rd_en && (count_q != '0);
        wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({do_wr, do_rd})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers, synchronously flushed by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout        = mem_q[rd_ptr_q];
    assign empty       = (count_q == '0);
    assign nearly_full = (count_q >= CNT_NEARLY);

endmodule

// File: rtl/filter_counter.sv
// Event counter with synchronous clear; wraps, or saturates when SAT_EN is set.
module filter_counter #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter bit          SAT_EN    = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q, count_d;

    // Next count: clear dominates a simultaneous increment
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            if (!(SAT_EN && (count_q == '1))) begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/ingress_mac_csum_filter.sv
// Ingress filter: drops physical-port packets with a runt header, bad IP
// checksum or foreign destination MAC; everything else passes unchanged.
// Define DROP_CNT_SAT_EN to make the statistics counters saturate instead of wrap.
module ingress_mac_csum_filter
    import ingress_filter_pkg::*;
#(
    parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned NUM_PORTS            = 4,
    parameter int unsigned SRC_PORT_POS         = 16,
    parameter int unsigned CSUM_POS             = 48,
    parameter int unsigned FIFO_DEPTH_BITS      = 4,
    parameter int unsigned CNT_WIDTH            = 32
) (
    input  logic                                 AXI_ACLK,
    input  logic                                 AXI_RESETN,
    input  logic [C_M_AXIS_DATA_WIDTH-1:0]       S_AXIS_TDATA,
    input  logic [C_M_AXIS_DATA_WIDTH/8-1:0]     S_AXIS_TSTRB,
    input  logic [C_M_AXIS_TUSER_WIDTH-1:0]      S_AXIS_TUSER,
    input  logic                                 S_AXIS_TVALID,
    input  logic                                 S_AXIS_TLAST,
    output logic                                 S_AXIS_TREADY,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       M_AXIS_TDATA,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     M_AXIS_TSTRB,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      M_AXIS_TUSER,
    output logic                                 M_AXIS_TVALID,
    output logic                                 M_AXIS_TLAST,
    input  logic                                 M_AXIS_TREADY,
    input  logic [48*NUM_PORTS-1:0]              mac_table,
    input  logic [15:0]                          exp_csum,
    input  logic                                 clear_counters,
    output logic [CNT_WIDTH-1:0]                 csum_drop_count,
    output logic [CNT_WIDTH-1:0]                 mac_drop_count,
    output logic [CNT_WIDTH-1:0]                 runt_drop_count,
    output logic [CNT_WIDTH-1:0]                 pass_count,
    output logic [RSN_W-1:0]                     last_drop_reason
);

`ifdef DROP_CNT_SAT_EN
    localparam bit CNT_SAT = 1'b1;
`else
    localparam bit CNT_SAT = 1'b0;
`endif

    localparam int unsigned DW     = C_M_AXIS_DATA_WIDTH;
    localparam int unsigned SW     = C_M_AXIS_DATA_WIDTH / 8;
    localparam int unsigned UW     = C_M_AXIS_TUSER_WIDTH;
    localparam int unsigned FIFO_W = DW + SW + UW + 1;

    logic [FIFO_W-1:0] fifo_din, fifo_dout;
    logic              fifo_wr, fifo_rd, fifo_empty, fifo_nearly_full;

    logic [DW-1:0]     head_tdata;
    logic [SW-1:0]     head_tstrb;
    logic [UW-1:0]     head_tuser;
    logic              head_tlast;

    logic [NUM_PORTS-1:0] src_hit;
    logic                 src_found;
    logic [47:0]          own_mac;
    logic [47:0]          dst_mac;
    logic                 is_phys, is_runt, is_csum, is_mac, is_drop;

    filter_state_e     state_q, state_d;
    logic [RSN_W-1:0]  reason_q, reason_d;
    logic              pass_inc, csum_inc, mac_inc, runt_inc;

    assign fifo_din      = {S_AXIS_TLAST, S_AXIS_TUSER, S_AXIS_TSTRB, S_AXIS_TDATA};
    assign fifo_wr       = S_AXIS_TVALID && S_AXIS_TREADY;
    assign S_AXIS_TREADY = !fifo_nearly_full;

    fallthrough_small_fifo #(
        .WIDTH          (FIFO_W),
        .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_in_fifo (
        .din         (fifo_din),
        .wr_en       (fifo_wr),
        .rd_en       (fifo_rd),
        .dout        (fifo_dout),
        .nearly_full (fifo_nearly_full),
        .empty       (fifo_empty),
        .reset       (!AXI_RESETN),
        .clk         (AXI_ACLK)
    );

    assign {head_tlast, head_tuser, head_tstrb, head_tdata} = fifo_dout;
    assign dst_mac = head_tdata[DW-1 -: 48];

    // Source port decode: lowest set one-hot bit selects the port MAC to compare against
    always_comb begin
        src_hit   = '0;
        src_found = 1'b0;
        own_mac   = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            src_hit[i] = head_tuser[SRC_PORT_POS + 2*i];
            if (src_hit[i] && !src_found) begin
                own_mac   = mac_table[48*i +: 48];
                src_found = 1'b1;
            end
        end
    end

    // Header classification with priority runt > csum > mac; host traffic is never dropped
    always_comb begin
        is_phys = |src_hit;
        is_runt = is_phys && head_tlast;
        is_csum = is_phys && !is_runt && (head_tdata[CSUM_POS +: 16] != exp_csum);
        is_mac  = is_phys && !is_runt && !is_csum &&
                  (dst_mac != own_mac) && (dst_mac != BCAST_MAC);
        is_drop = is_runt || is_csum || is_mac;
    end

    // Next-state, FIFO pop and counter strobes
    always_comb begin
        state_d  = state_q;
        reason_d = reason_q;
        fifo_rd  = 1'b0;
        pass_inc = 1'b0;
        csum_inc = 1'b0;
        mac_inc  = 1'b0;
        runt_inc = 1'b0;
        unique case (state_q)
            HDR: begin
                if (!fifo_empty) begin
                    if (is_drop) begin
                        reason_d           = '0;
                        reason_d[RSN_RUNT] = is_runt;
                        reason_d[RSN_MAC]  = is_mac;
                        reason_d[RSN_CSUM] = is_csum;
                        runt_inc           = is_runt;
                        csum_inc           = is_csum;
                        mac_inc            = is_mac;
                        // A single-beat drop is consumed here so no DROP pass is needed
                        if (head_tlast) begin
                            fifo_rd = 1'b1;
                        end else begin
                            state_d = DROP;
                        end
                    end else begin
                        pass_inc = 1'b1;
                        state_d  = PASS;
                    end
                end
            end
            PASS: begin
                if (!fifo_empty && M_AXIS_TREADY) begin
                    fifo_rd = 1'b1;
                    if (head_tlast) begin
                        state_d = HDR;
                    end
                end
            end
            DROP: begin
                if (!fifo_empty) begin
                    fifo_rd = 1'b1;
                    if (head_tlast) begin
                        state_d = HDR;
                    end
                end
            end
            default: state_d = HDR;
        endcase
    end

    // Filter FSM and drop-reason register
    always_ff @(posedge AXI_ACLK) begin
        if (!AXI_RESETN) begin
            state_q  <= HDR;
            reason_q <= '0;
        end else begin
            state_q  <= state_d;
            reason_q <= reason_d;
        end
    end

    assign M_AXIS_TVALID    = (state_q == PASS) && !fifo_empty;
    assign M_AXIS_TDATA     = head_tdata;
    assign M_AXIS_TSTRB     = head_tstrb;
    assign M_AXIS_TUSER     = head_tuser;
    assign M_AXIS_TLAST     = head_tlast;
    assign last_drop_reason = reason_q;

    filter_counter #(.CNT_WIDTH(CNT_WIDTH), .SAT_EN(CNT_SAT)) u_pass_cnt (
        .clk(AXI_ACLK), .rst_n(AXI_RESETN), .inc(pass_inc), .clr(clear_counters), .count(pass_count)
    );
    filter_counter #(.CNT_WIDTH(CNT_WIDTH), .SAT_EN(CNT_SAT)) u_csum_cnt (
        .clk(AXI_ACLK), .rst_n(AXI_RESETN), .inc(csum_inc), .clr(clear_counters), .count(csum_drop_count)
    );
    filter_counter #(.CNT_WIDTH(CNT_WIDTH), .SAT_EN(CNT_SAT)) u_mac_cnt (
        .clk(AXI_ACLK), .rst_n(AXI_RESETN), .inc(mac_inc), .clr(clear_counters), .count(mac_drop_count)
    );
    filter_counter #(.CNT_WIDTH(CNT_WIDTH), .SAT_EN(CNT_SAT)) u_runt_cnt (
        .clk(AXI_ACLK), .rst_n(AXI_RESETN), .inc(runt_inc), .clr(clear_counters), .count(runt_drop_count)
    );

endmodule
